// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, arbiter FSM states and the machine word.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_XFER = 2'd1,
        D_XFER = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the icache and dcache; data side wins,
// bounded by a starvation counter that forces an instruction fill through.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_t          state, next_state;
    logic [STARVE_W-1:0] starve, next_starve;
    ramstate_t           rstate;
    logic                d_req;
    logic                i_done;
    logic                d_done;

    assign rstate = ramstate_t'(ramstate);
    assign d_req  = dREN | dWEN;
    assign iload  = ramload;
    assign dload  = ramload;

    // State and starvation counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            starve <= '0;
        end else begin
            state  <= next_state;
            starve <= next_starve;
        end
    end

    // Grant decision, RAM port drive and wait generation from the live requests.
    always_comb begin
        next_state  = state;
        next_starve = starve;
        iwait       = 1'b1;
        dwait       = 1'b1;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        i_done      = 1'b0;
        d_done      = 1'b0;

        case (state)
            IDLE: begin
                if (d_req && (!iREN || (starve < STARVE_W'(STARVE_MAX)))) begin
                    next_state = D_XFER;
                end else if (iREN) begin
                    next_state = I_XFER;
                end
            end
            I_XFER: begin
                // A dropped request aborts: enables fall in the same cycle.
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (rstate == ACCESS) begin
                        iwait      = 1'b0;
                        i_done     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            D_XFER: begin
                if (!d_req) begin
                    next_state = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (rstate == ACCESS) begin
                        dwait      = 1'b0;
                        d_done     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // Count data completions that overtook a waiting fill; saturate at the limit.
        if (!iREN || i_done) begin
            next_starve = '0;
        end else if (d_done && (starve < STARVE_W'(STARVE_MAX))) begin
            next_starve = starve + STARVE_W'(1);
        end
    end

endmodule
